arp_eth_rx_filt: RTL and testbench

//  Parametrised ARP receiver: eth header + AXI-S payload in, decoded ARP frames out via internal queue.

---
 rtl/arp_pkg.sv | 35 +++
 rtl/arp_frame_fifo.sv | 44 ++++
 rtl/arp_eth_rx_filt.sv | 239 +++++++++++++++++++++++
 tb/tb_arp_eth_rx_filt.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arp_pkg.sv
// rtl/arp_pkg.sv - ARP field constants, FSM states and decoded-frame record
package arp_pkg;

  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN_ETH   = 8'd6;
  localparam logic [7:0]  ARP_PLEN_IPV4  = 8'd4;
  localparam logic [15:0] ARP_OPER_REQ   = 16'd1;
  localparam logic [15:0] ARP_OPER_REPLY = 16'd2;
  localparam int          ARP_HDR_LEN    = 28;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_DRAIN = 2'd2
  } arp_state_e;

  typedef struct packed {
    logic [47:0] eth_dest_mac;
    logic [47:0] eth_src_mac;
    logic [15:0] eth_type;
    logic [15:0] arp_htype;
    logic [15:0] arp_ptype;
    logic [7:0]  arp_hlen;
    logic [7:0]  arp_plen;
    logic [15:0] arp_oper;
    logic [47:0] arp_sha;
    logic [31:0] arp_spa;
    logic [47:0] arp_tha;
    logic [31:0] arp_tpa;
  } arp_frame_t;

  localparam int ARP_FRAME_W = $bits(arp_frame_t);

endpackage

// File: rtl/arp_frame_fifo.sv
// rtl/arp_frame_fifo.sv - first-word-fall-through queue of decoded ARP frames
module arp_frame_fifo #(
  parameter int WIDTH = 336,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             push_i,
  output logic             full_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             empty, pop, push_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = !empty && rd_ready_i;
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok = push_i && (!full_o || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_valid_o = !empty;
  assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/arp_eth_rx_filt.sv
// rtl/arp_eth_rx_filt.sv - ARP receive parser with field validation, local-IP filter and frame queue
module arp_eth_rx_filt
  import arp_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,
  input  logic [31:0]           local_ip,
  input  logic                  filter_enable,
  output logic                  m_frame_valid,
  input  logic                  m_frame_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [15:0]           m_arp_htype,
  output logic [15:0]           m_arp_ptype,
  output logic [7:0]            m_arp_hlen,
  output logic [7:0]            m_arp_plen,
  output logic [15:0]           m_arp_oper,
  output logic [47:0]           m_arp_sha,
  output logic [31:0]           m_arp_spa,
  output logic [47:0]           m_arp_tha,
  output logic [31:0]           m_arp_tpa,
  output logic                  busy,
  output logic                  error_header_early_termination,
  output logic                  error_invalid_header,
  output logic [CNT_WIDTH-1:0]  cnt_rx_ok,
  output logic [CNT_WIDTH-1:0]  cnt_drop_err,
  output logic [CNT_WIDTH-1:0]  cnt_drop_filt,
  output logic [CNT_WIDTH-1:0]  cnt_overflow
);
  localparam int         LAST_BYTE = ARP_HDR_LEN - 1;
  localparam logic [5:0] LAST_BEAT = 6'(LAST_BYTE / KEEP_WIDTH);
  localparam int         LAST_LANE = LAST_BYTE % KEEP_WIDTH;
  localparam int         HW        = ARP_HDR_LEN * 8;

  arp_state_e            state_q, state_d;
  logic [5:0]            beat_q, beat_d;
  // Header bytes stored big-endian: byte 0 in the top bits, so fields slice out directly.
  logic [HW-1:0]         hdr_q, hdr_d;
  logic [47:0]           dmac_q, smac_q;
  logic [15:0]           etype_q;
  logic                  hdr_ready_q, tready_q, busy_q, early_q, inv_q;
  logic [CNT_WIDTH-1:0]  ok_q, err_q, filt_q, ovf_q;

  logic [KEEP_WIDTH-1:0] keep;
  logic                  hdr_acc, beat, byte27, commit, early;
  logic                  bad_hdr, push, inc_ok, inc_err, inc_filt, inc_ovf, inv;
  logic                  fifo_full, pop;
  arp_frame_t            frame, head;
  logic [ARP_FRAME_W-1:0] head_bits;

  assign keep    = (KEEP_ENABLE != 0) ? s_eth_payload_axis_tkeep : '1;
  assign hdr_acc = s_eth_hdr_valid && hdr_ready_q;
  assign beat    = s_eth_payload_axis_tvalid && tready_q;
  assign byte27  = beat && (beat_q == LAST_BEAT) && keep[LAST_LANE];

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    hdr_d   = hdr_q;
    commit  = 1'b0;
    early   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hdr_acc) begin
          state_d = ST_HDR;
          beat_d  = '0;
          hdr_d   = '0;
        end
      end
      ST_HDR: begin
        if (beat) begin
          for (int k = 0; k < ARP_HDR_LEN; k++) begin
            if (beat_q == 6'(k / KEEP_WIDTH) && keep[k % KEEP_WIDTH])
              hdr_d[HW-8-8*k +: 8] = s_eth_payload_axis_tdata[8*(k % KEEP_WIDTH) +: 8];
          end
          if (byte27) begin
            commit  = s_eth_payload_axis_tlast;
            state_d = s_eth_payload_axis_tlast ? ST_IDLE : ST_DRAIN;
          end else if (s_eth_payload_axis_tlast) begin
            early   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + 6'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (beat && s_eth_payload_axis_tlast) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    frame.eth_dest_mac = dmac_q;
    frame.eth_src_mac  = smac_q;
    frame.eth_type     = etype_q;
    frame.arp_htype    = hdr_d[223:208];
    frame.arp_ptype    = hdr_d[207:192];
    frame.arp_hlen     = hdr_d[191:184];
    frame.arp_plen     = hdr_d[183:176];
    frame.arp_oper     = hdr_d[175:160];
    frame.arp_sha      = hdr_d[159:112];
    frame.arp_spa      = hdr_d[111:80];
    frame.arp_tha      = hdr_d[79:32];
    frame.arp_tpa      = hdr_d[31:0];
  end

  assign bad_hdr = (frame.arp_htype != ARP_HTYPE_ETH) || (frame.arp_ptype != ARP_PTYPE_IPV4) ||
                   (frame.arp_hlen != ARP_HLEN_ETH) || (frame.arp_plen != ARP_PLEN_IPV4) ||
                   !((frame.arp_oper == ARP_OPER_REQ) || (frame.arp_oper == ARP_OPER_REPLY));
  assign pop = m_frame_valid && m_frame_ready;

  always_comb begin
    push     = 1'b0;
    inc_ok   = 1'b0;
    inc_err  = early;
    inc_filt = 1'b0;
    inc_ovf  = 1'b0;
    inv      = 1'b0;
    if (commit) begin
      if (s_eth_payload_axis_tuser) begin
        inc_err = 1'b1;
      end else if (bad_hdr) begin
        inv     = 1'b1;
        inc_err = 1'b1;
      end else if (filter_enable && (frame.arp_tpa != local_ip)) begin
        inc_filt = 1'b1;
      end else if (fifo_full && !pop) begin
        inc_ovf = 1'b1;
      end else begin
        push   = 1'b1;
        inc_ok = 1'b1;
      end
    end
  end

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      hdr_q       <= '0;
      dmac_q      <= '0;
      smac_q      <= '0;
      etype_q     <= '0;
      hdr_ready_q <= 1'b0;
      tready_q    <= 1'b0;
      busy_q      <= 1'b0;
      early_q     <= 1'b0;
      inv_q       <= 1'b0;
      ok_q        <= '0;
      err_q       <= '0;
      filt_q      <= '0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      hdr_q       <= hdr_d;
      hdr_ready_q <= (state_d == ST_IDLE);
      tready_q    <= (state_d == ST_HDR) || (state_d == ST_DRAIN);
      busy_q      <= (state_d != ST_IDLE);
      early_q     <= early;
      inv_q       <= inv;
      if (hdr_acc) begin
        dmac_q  <= s_eth_dest_mac;
        smac_q  <= s_eth_src_mac;
        etype_q <= s_eth_type;
      end
      if (inc_ok)   ok_q   <= sat_inc(ok_q);
      if (inc_err)  err_q  <= sat_inc(err_q);
      if (inc_filt) filt_q <= sat_inc(filt_q);
      if (inc_ovf)  ovf_q  <= sat_inc(ovf_q);
    end
  end

  arp_frame_fifo #(
    .WIDTH (ARP_FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_data_i  (frame),
    .push_i     (push),
    .full_o     (fifo_full),
    .rd_data_o  (head_bits),
    .rd_valid_o (m_frame_valid),
    .rd_ready_i (m_frame_ready)
  );

  assign head = arp_frame_t'(head_bits);

  assign s_eth_hdr_ready                = hdr_ready_q;
  assign s_eth_payload_axis_tready      = tready_q;
  assign busy                           = busy_q;
  assign error_header_early_termination = early_q;
  assign error_invalid_header           = inv_q;
  assign cnt_rx_ok                      = ok_q;
  assign cnt_drop_err                   = err_q;
  assign cnt_drop_filt                  = filt_q;
  assign cnt_overflow                   = ovf_q;
  assign m_eth_dest_mac                 = head.eth_dest_mac;
  assign m_eth_src_mac                  = head.eth_src_mac;
  assign m_eth_type                     = head.eth_type;
  assign m_arp_htype                    = head.arp_htype;
  assign m_arp_ptype                    = head.arp_ptype;
  assign m_arp_hlen                     = head.arp_hlen;
  assign m_arp_plen                     = head.arp_plen;
  assign m_arp_oper                     = head.arp_oper;
  assign m_arp_sha                      = head.arp_sha;
  assign m_arp_spa                      = head.arp_spa;
  assign m_arp_tha                      = head.arp_tha;
  assign m_arp_tpa                      = head.arp_tpa;

endmodule

// File: tb/tb_arp_eth_rx_filt.sv
// tb/tb_arp_eth_rx_filt.sv - scoreboard bench for the ARP receive filter
module tb_arp_eth_rx_filt;
  import arp_pkg::*;

  localparam int DW = 32;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_eth_hdr_valid = 1'b0;
  logic          s_eth_hdr_ready;
  logic [47:0]   s_eth_dest_mac = '0;
  logic [47:0]   s_eth_src_mac = '0;
  logic [15:0]   s_eth_type = '0;
  logic [DW-1:0] tdata = '0;
  logic [KW-1:0] tkeep = '0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic          tlast = 1'b0;
  logic          tuser = 1'b0;
  logic [31:0]   local_ip = 32'h0A000001;
  logic          filter_enable = 1'b1;
  logic          m_frame_valid;
  logic          m_frame_ready = 1'b1;
  logic [47:0]   m_eth_dest_mac, m_eth_src_mac, m_arp_sha, m_arp_tha;
  logic [15:0]   m_eth_type, m_arp_htype, m_arp_ptype, m_arp_oper;
  logic [7:0]    m_arp_hlen, m_arp_plen;
  logic [31:0]   m_arp_spa, m_arp_tpa;
  logic          busy, err_early, err_inv;
  logic [15:0]   cnt_rx_ok, cnt_drop_err, cnt_drop_filt, cnt_overflow;

  arp_eth_rx_filt #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_eth_hdr_valid(s_eth_hdr_valid), .s_eth_hdr_ready(s_eth_hdr_ready),
    .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
    .s_eth_payload_axis_tdata(tdata), .s_eth_payload_axis_tkeep(tkeep),
    .s_eth_payload_axis_tvalid(tvalid), .s_eth_payload_axis_tready(tready),
    .s_eth_payload_axis_tlast(tlast), .s_eth_payload_axis_tuser(tuser),
    .local_ip(local_ip), .filter_enable(filter_enable),
    .m_frame_valid(m_frame_valid), .m_frame_ready(m_frame_ready),
    .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac), .m_eth_type(m_eth_type),
    .m_arp_htype(m_arp_htype), .m_arp_ptype(m_arp_ptype), .m_arp_hlen(m_arp_hlen),
    .m_arp_plen(m_arp_plen), .m_arp_oper(m_arp_oper), .m_arp_sha(m_arp_sha),
    .m_arp_spa(m_arp_spa), .m_arp_tha(m_arp_tha), .m_arp_tpa(m_arp_tpa),
    .busy(busy), .error_header_early_termination(err_early), .error_invalid_header(err_inv),
    .cnt_rx_ok(cnt_rx_ok), .cnt_drop_err(cnt_drop_err), .cnt_drop_filt(cnt_drop_filt),
    .cnt_overflow(cnt_overflow)
  );

  always #5 clk = ~clk;

  arp_frame_t sb[$];
  arp_frame_t last_exp, got, want;
  int checks = 0, fails = 0;
  int exp_ok = 0, exp_err = 0, exp_filt = 0, exp_ovf = 0;
  int n_early = 0, n_inv = 0, stalls = 0;
  logic [7:0] pay [0:63];
  int pay_len = 0;
  logic [47:0] cur_smac = 48'h020000000001;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (err_early) n_early++;
      if (err_inv)   n_inv++;
      if (m_frame_valid && m_frame_ready) begin
        got.eth_dest_mac = m_eth_dest_mac; got.eth_src_mac = m_eth_src_mac;
        got.eth_type = m_eth_type;         got.arp_htype = m_arp_htype;
        got.arp_ptype = m_arp_ptype;       got.arp_hlen = m_arp_hlen;
        got.arp_plen = m_arp_plen;         got.arp_oper = m_arp_oper;
        got.arp_sha = m_arp_sha;           got.arp_spa = m_arp_spa;
        got.arp_tha = m_arp_tha;           got.arp_tpa = m_arp_tpa;
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL frame_unexpected: got spa=%h tpa=%h expected none", got.arp_spa, got.arp_tpa);
        end else begin
          want = sb.pop_front();
          if (got !== want) begin
            fails++;
            $display("FAIL frame: got oper=%h spa=%h tpa=%h sha=%h smac=%h expected oper=%h spa=%h tpa=%h sha=%h smac=%h",
                     got.arp_oper, got.arp_spa, got.arp_tpa, got.arp_sha, got.eth_src_mac,
                     want.arp_oper, want.arp_spa, want.arp_tpa, want.arp_sha, want.eth_src_mac);
          end
        end
      end
    end
  end

  task automatic build(input logic [15:0] htype, input logic [15:0] ptype, input logic [7:0] hlen,
                       input logic [7:0] plen, input logic [15:0] oper, input logic [31:0] spa,
                       input logic [31:0] tpa, input int len);
    logic [47:0] sha, tha;
    sha = {40'h0211223344, spa[7:0]};
    tha = (oper == 16'd2) ? 48'h02AABBCCDDEE : 48'h0;
    pay[0] = htype[15:8]; pay[1] = htype[7:0];
    pay[2] = ptype[15:8]; pay[3] = ptype[7:0];
    pay[4] = hlen;        pay[5] = plen;
    pay[6] = oper[15:8];  pay[7] = oper[7:0];
    for (int i = 0; i < 6; i++) pay[8 + i]  = sha[47 - 8*i -: 8];
    for (int i = 0; i < 4; i++) pay[14 + i] = spa[31 - 8*i -: 8];
    for (int i = 0; i < 6; i++) pay[18 + i] = tha[47 - 8*i -: 8];
    for (int i = 0; i < 4; i++) pay[24 + i] = tpa[31 - 8*i -: 8];
    for (int i = 28; i < 64; i++) pay[i] = 8'hA5 ^ 8'(i);
    pay_len = len;
    last_exp.eth_dest_mac = 48'hFFFFFFFFFFFF; last_exp.eth_src_mac = cur_smac;
    last_exp.eth_type = 16'h0806;  last_exp.arp_htype = htype; last_exp.arp_ptype = ptype;
    last_exp.arp_hlen = hlen;      last_exp.arp_plen = plen;   last_exp.arp_oper = oper;
    last_exp.arp_sha = sha;        last_exp.arp_spa = spa;     last_exp.arp_tha = tha;
    last_exp.arp_tpa = tpa;
  endtask

  // Called and returns at a falling edge so back-to-back calls run at full rate.
  task automatic send_frame(input logic user, input int abort_beat);
    int nb, to, idx;
    nb = (pay_len + KW - 1) / KW;
    s_eth_hdr_valid = 1'b1; s_eth_dest_mac = 48'hFFFFFFFFFFFF;
    s_eth_src_mac = cur_smac; s_eth_type = 16'h0806;
    to = 0;
    while (!s_eth_hdr_ready && to < 1000) begin @(negedge clk); to++; end
    if (to >= 1000) begin
      chk("hdr_ready_timeout", 64'd0, 64'd1);
      s_eth_hdr_valid = 1'b0;
      return;
    end
    @(posedge clk); @(negedge clk);
    s_eth_hdr_valid = 1'b0;
    for (int b = 0; b < nb; b++) begin
      if (b == abort_beat) begin tvalid = 1'b0; return; end
      for (int l = 0; l < KW; l++) begin
        idx = b*KW + l;
        tkeep[l] = (idx < pay_len);
        tdata[8*l +: 8] = (idx < pay_len) ? pay[idx] : 8'h00;
      end
      tvalid = 1'b1; tlast = (b == nb - 1); tuser = (b == nb - 1) ? user : 1'b0;
      if (!tready) stalls++;
      to = 0;
      while (!tready && to < 1000) begin @(negedge clk); to++; end
      if (to >= 1000) begin chk("tready_timeout", 64'd0, 64'd1); tvalid = 1'b0; return; end
      @(posedge clk); @(negedge clk);
    end
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  task automatic drain();
    int to = 0;
    while (sb.size() != 0 && to < 2000) begin @(negedge clk); to++; end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_cnt_rx_ok"},     64'(cnt_rx_ok),     64'(exp_ok));
    chk({tag, "_cnt_drop_err"},  64'(cnt_drop_err),  64'(exp_err));
    chk({tag, "_cnt_drop_filt"}, 64'(cnt_drop_filt), 64'(exp_filt));
    chk({tag, "_cnt_overflow"},  64'(cnt_overflow),  64'(exp_ovf));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hdr_ready"}, 64'(s_eth_hdr_ready), 64'd0);
    chk({tag, "_tready"},    64'(tready),          64'd0);
    chk({tag, "_m_valid"},   64'(m_frame_valid),   64'd0);
    chk({tag, "_busy"},      64'(busy),            64'd0);
    chk({tag, "_m_tpa"},     64'(m_arp_tpa),       64'd0);
    chk({tag, "_cnt_rx_ok"}, 64'(cnt_rx_ok),       64'd0);
    chk({tag, "_cnt_err"},   64'(cnt_drop_err),    64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("hdr_ready_after_reset", 64'(s_eth_hdr_ready), 64'd1);

    // Request addressed to us, exactly 28 bytes: commit on the beat carrying byte 27.
    build(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1, 32'h0A000063, 32'h0A000001, 28);
    sb.push_back(last_exp); exp_ok++;
    send_frame(1'b0, -1);
    chk("valid_after_commit", 64'(m_frame_valid), 64'd1);

    // Padded reply for another host: filtered, then accepted with the filter off.
    cur_smac = 48'h020000000002;
    build(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd2, 32'h0A000064, 32'h0A000002, 60);
    send_frame(1'b0, -1); exp_filt++;
    filter_enable = 1'b0;
    sb.push_back(last_exp); exp_ok++;
    send_frame(1'b0, -1);
    filter_enable = 1'b1;

    // Early tlast on byte 19, then a 30-byte frame with a partial last beat.
    build(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1, 32'h0A000065, 32'h0A000001, 20);
    send_frame(1'b0, -1); exp_err++;
    build(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1, 32'h0A000066, 32'h0A000001, 30);
    sb.push_back(last_exp); exp_ok++;
    send_frame(1'b0, -1);

    // Bad hlen, tuser on a good frame, bad oper.
    build(16'h0001, 16'h0800, 8'd8, 8'd4, 16'd1, 32'h0A000067, 32'h0A000001, 28);
    send_frame(1'b0, -1); exp_err++;
    build(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1, 32'h0A000068, 32'h0A000001, 28);
    send_frame(1'b1, -1); exp_err++;
    build(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd3, 32'h0A000069, 32'h0A000001, 28);
    send_frame(1'b0, -1); exp_err++;
    drain();
    repeat (2) @(negedge clk);
    chk_cnts("basic");
    chk("early_pulses", 64'(n_early), 64'd1);
    chk("invalid_pulses", 64'(n_inv), 64'd2);
    chk("busy_idle", 64'(busy), 64'd0);

    // Six back-to-back frames into a depth-4 queue with the consumer stalled.
    m_frame_ready = 1'b0;
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      cur_smac = 48'h020000000010 + 48'(i);
      build(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1, 32'h0A000070 + 32'(i), 32'h0A000001, 28);
      if (i < 4) begin sb.push_back(last_exp); exp_ok++; end
      else exp_ovf++;
      send_frame(1'b0, -1);
    end
    repeat (2) @(negedge clk);
    chk("burst_tready_stalls", 64'(stalls), 64'd0);
    chk("burst_m_valid", 64'(m_frame_valid), 64'd1);
    chk("burst_head_spa", 64'(m_arp_spa), 64'h0A000070);
    chk_cnts("burst");
    m_frame_ready = 1'b1;
    drain();

    // Reset in the middle of a header with two frames queued.
    m_frame_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      build(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd2, 32'h0A000080 + 32'(i), 32'h0A000001, 28);
      sb.push_back(last_exp); exp_ok++;
      send_frame(1'b0, -1);
    end
    build(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1, 32'h0A000090, 32'h0A000001, 28);
    send_frame(1'b0, 2);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    chk("pre_reset_ok", 64'(cnt_rx_ok), 64'(exp_ok));
    chk("pre_reset_valid", 64'(m_frame_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    sb.delete();
    exp_ok = 0; exp_err = 0; exp_filt = 0; exp_ovf = 0;
    @(negedge clk);
    rst_n = 1'b1;
    m_frame_ready = 1'b1;
    @(negedge clk);
    build(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1, 32'h0A0000A0, 32'h0A000001, 28);
    sb.push_back(last_exp); exp_ok++;
    send_frame(1'b0, -1);
    drain();
    repeat (2) @(negedge clk);
    chk_cnts("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
